// File: rtl/alu_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// alu_scheduler_pkg
//   Shared definitions for the ALU scheduler: default ALU word width, the
//   FUNC_* opcodes understood by the shared ALU, and the scheduler state type.
//   No ports; imported by alu_scheduler and rr_arbiter2.
// -----------------------------------------------------------------------------
package alu_scheduler_pkg;

  // Default ALU word width; wide operations are twice this.
  localparam int DEFAULT_WORD = 16;

  // ALU function codes.
  localparam logic [3:0] FUNC_ADD = 4'h0;  // a + b + carry_in
  localparam logic [3:0] FUNC_SUB = 4'h1;  // a - b - carry_in, carry_out = borrow
  localparam logic [3:0] FUNC_AND = 4'h2;
  localparam logic [3:0] FUNC_OR  = 4'h3;
  localparam logic [3:0] FUNC_XOR = 4'h4;

  // Scheduler sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } sched_state_t;

endpackage

// File: rtl/alu_scheduler_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter, purely combinational. The priority pointer
//   register is owned by the instantiating block.
//   Ports:
//     req_i   [1:0]  request vector (bit N = requester N)
//     ptr_i          requester that wins when both request
//     grant_o [1:0]  one-hot grant (all zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arbiter2
  import alu_scheduler_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_grant
      localparam logic SELF = 1'(gi);
      // Win if requesting and either the other side is quiet or the pointer
      // favours this side.
      assign grant_o[gi] = req_i[gi] & (~req_i[1-gi] | (ptr_i == SELF));
    end
  endgenerate

endmodule

// File: rtl/alu_scheduler.sv
// -----------------------------------------------------------------------------
// alu_scheduler
//   Shares one combinational WORD-bit ALU between two requesters. Narrow
//   operations take one ALU pass; wide (2*WORD) operations take two passes,
//   low word then high word, with the carry chained through a register.
//   Only one operation is in flight at a time.
//   Ports:
//     clk, rst                      clock, asynchronous active-high reset
//     reqN_valid/ready              request handshake (ready = 1-cycle accept)
//     reqN_opcode/wide/a/b          request payload (narrow uses a/b low word)
//     resp_valid/ready              response handshake
//     resp_id/result/carry          response payload, held until accepted
//     alu_inA/inB/opcode/carry_in   shared ALU inputs (0 when not in use)
//     alu_result/carry_out          shared ALU outputs (combinational)
// -----------------------------------------------------------------------------
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int WORD = DEFAULT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_opcode,
  input  logic              req0_wide,
  input  logic [2*WORD-1:0] req0_a,
  input  logic [2*WORD-1:0] req0_b,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_opcode,
  input  logic              req1_wide,
  input  logic [2*WORD-1:0] req1_a,
  input  logic [2*WORD-1:0] req1_b,
  // response
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [2*WORD-1:0] resp_result,
  output logic              resp_carry,
  // shared ALU
  output logic [WORD-1:0]   alu_inA,
  output logic [WORD-1:0]   alu_inB,
  output logic [3:0]        alu_opcode,
  output logic              alu_carry_in,
  input  logic [WORD-1:0]   alu_result,
  input  logic              alu_carry_out
);

  sched_state_t      state_q;
  logic              ptr_q;
  logic              id_q;
  logic              wide_q;
  logic [WORD-1:0]   a_hi_q;
  logic [WORD-1:0]   b_hi_q;
  logic [2*WORD-1:0] result_q;
  logic              carry_q;
  logic              resp_valid_q;
  logic [WORD-1:0]   alu_a_q;
  logic [WORD-1:0]   alu_b_q;
  logic [3:0]        alu_op_q;
  logic              alu_cin_q;

  logic [1:0]        grant;
  logic              sel_id;
  logic [3:0]        sel_op;
  logic              sel_wide;
  logic [2*WORD-1:0] sel_a;
  logic [2*WORD-1:0] sel_b;

  rr_arbiter2 u_arb (
    .req_i   ({req1_valid, req0_valid}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // Payload of the granted requester (grant is one-hot).
  assign sel_id   = grant[1];
  assign sel_op   = sel_id ? req1_opcode : req0_opcode;
  assign sel_wide = sel_id ? req1_wide   : req0_wide;
  assign sel_a    = sel_id ? req1_a      : req0_a;
  assign sel_b    = sel_id ? req1_b      : req0_b;

  // Accept strobe only while idle; forced low while reset is held so every
  // output reads 0 during reset even if requesters keep valid asserted.
  assign req0_ready = (state_q == ST_IDLE) & ~rst & grant[0];
  assign req1_ready = (state_q == ST_IDLE) & ~rst & grant[1];

  // Response payload is presented only while the response is valid.
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_valid_q & id_q;
  assign resp_carry  = resp_valid_q & carry_q;
  assign resp_result = resp_valid_q ? result_q : '0;

  assign alu_inA      = alu_a_q;
  assign alu_inB      = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign alu_carry_in = alu_cin_q;

  // The ALU input registers are loaded one edge ahead of the pass that uses
  // them, so the ALU sees stable registered operands for the whole LO/HI cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 1'b0;
      id_q         <= 1'b0;
      wide_q       <= 1'b0;
      a_hi_q       <= '0;
      b_hi_q       <= '0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_cin_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            id_q      <= sel_id;
            wide_q    <= sel_wide;
            a_hi_q    <= sel_a[2*WORD-1:WORD];
            b_hi_q    <= sel_b[2*WORD-1:WORD];
            result_q  <= '0;
            carry_q   <= 1'b0;
            alu_a_q   <= sel_a[WORD-1:0];
            alu_b_q   <= sel_b[WORD-1:0];
            alu_op_q  <= sel_op;
            alu_cin_q <= 1'b0;
            state_q   <= ST_LO;
          end
        end

        ST_LO: begin
          result_q[WORD-1:0] <= alu_result;
          carry_q            <= alu_carry_out;
          if (wide_q) begin
            // Set up the high pass; opcode stays, carry is chained.
            alu_a_q   <= a_hi_q;
            alu_b_q   <= b_hi_q;
            alu_cin_q <= alu_carry_out;
            state_q   <= ST_HI;
          end else begin
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            alu_cin_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= ST_RESP;
          end
        end

        ST_HI: begin
          result_q[2*WORD-1:WORD] <= alu_result;
          carry_q                 <= alu_carry_out;
          alu_a_q                 <= '0;
          alu_b_q                 <= '0;
          alu_op_q                <= '0;
          alu_cin_q               <= 1'b0;
          resp_valid_q            <= 1'b1;
          state_q                 <= ST_RESP;
        end

        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            // Hand priority to the requester that was not just served.
            ptr_q        <= ~id_q;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_ready, req0_wide;
  logic [3:0]  req0_opcode;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_wide;
  logic [3:0]  req1_opcode;
  logic [31:0] req1_a, req1_b;
  logic        resp_valid, resp_ready, resp_id, resp_carry;
  logic [31:0] resp_result;
  logic [15:0] alu_inA, alu_inB, alu_result;
  logic [3:0]  alu_opcode;
  logic        alu_carry_in, alu_carry_out;

  alu_scheduler dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_wide(req0_wide), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_wide(req1_wide), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  // Combinational 16-bit ALU standing in for the real one.
  logic [16:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (alu_opcode)
      FUNC_ADD: alu_t = {1'b0, alu_inA} + {1'b0, alu_inB} + 17'(alu_carry_in);
      FUNC_SUB: alu_t = {1'b0, alu_inA} - {1'b0, alu_inB} - 17'(alu_carry_in);
      FUNC_AND: alu_t = {1'b0, alu_inA & alu_inB};
      FUNC_OR:  alu_t = {1'b0, alu_inA | alu_inB};
      FUNC_XOR: alu_t = {1'b0, alu_inA ^ alu_inB};
      default:  alu_t = '0;
    endcase
  end
  assign alu_result    = alu_t[15:0];
  assign alu_carry_out = alu_t[16];

  int total = 0;
  int bad   = 0;

  // Whole-operation model: {carry, result} straight from 17/33-bit arithmetic.
  function automatic logic [32:0] model(input logic [3:0] op, input logic wide,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    logic [31:0] am, bm;
    am = wide ? a : {16'h0, a[15:0]};
    bm = wide ? b : {16'h0, b[15:0]};
    case (op)
      FUNC_ADD: r = {1'b0, am} + {1'b0, bm};
      FUNC_SUB: r = {1'b0, am} - {1'b0, bm};
      FUNC_AND: r = {1'b0, am & bm};
      FUNC_OR:  r = {1'b0, am | bm};
      FUNC_XOR: r = {1'b0, am ^ bm};
      default:  r = '0;
    endcase
    if (!wide) r = {r[16], 16'h0, r[15:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model / observation state.
  bit          m_busy, m_ptr, m_id, m_wide;
  int          m_cnt, m_lat, m_first;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [32:0] m_exp;
  logic [31:0] last_result;
  logic        last_carry, last_id, last_hi_cin;
  int          last_lat;
  int          grants[$];
  int          txn_no = 0;

  task automatic monitor();
    bit eg0, eg1;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_resp_side", {27'h0, req0_ready, req1_ready, resp_valid, resp_id, resp_carry, resp_result}, 64'h0);
        chk("rst_alu_side", {27'h0, alu_inA, alu_inB, alu_opcode, alu_carry_in}, 64'h0);
        m_busy = 0;
        m_ptr  = 0;
      end else if (!m_busy) begin
        eg0 = req0_valid && (!req1_valid || m_ptr == 1'b0);
        eg1 = req1_valid && (!req0_valid || m_ptr == 1'b1);
        chk("ready0", {63'h0, req0_ready}, {63'h0, eg0});
        chk("ready1", {63'h0, req1_ready}, {63'h0, eg1});
        chk("idle_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("idle_alu", {27'h0, alu_inA, alu_inB, alu_opcode, alu_carry_in}, 64'h0);
        if (req0_ready) grants.push_back(0);
        if (req1_ready) grants.push_back(1);
        if (eg0 || eg1) begin
          m_id    = eg1;
          m_op    = eg1 ? req1_opcode : req0_opcode;
          m_wide  = eg1 ? req1_wide : req0_wide;
          m_a     = eg1 ? req1_a : req0_a;
          m_b     = eg1 ? req1_b : req0_b;
          m_exp   = model(m_op, m_wide, m_a, m_b);
          m_busy  = 1;
          m_cnt   = 0;
          m_first = 0;
          m_lat   = m_wide ? 3 : 2;
        end
      end else begin
        m_cnt++;
        chk("busy_ready", {62'h0, req0_ready, req1_ready}, 64'h0);
        if (resp_valid && m_first == 0) m_first = m_cnt;
        if (m_cnt < m_lat) begin
          chk("early_resp_valid", {63'h0, resp_valid}, 64'h0);
          if (m_cnt == 1)
            chk("lo_alu", {27'h0, alu_opcode, alu_inA, alu_inB, alu_carry_in},
                {27'h0, m_op, m_a[15:0], m_b[15:0], 1'b0});
          else begin
            chk("hi_alu", {27'h0, alu_opcode, alu_inA, alu_inB, alu_carry_in},
                {27'h0, m_op, m_a[31:16], m_b[31:16],
                 model(m_op, 1'b0, {16'h0, m_a[15:0]}, {16'h0, m_b[15:0]})[32]});
            last_hi_cin = alu_carry_in;
          end
        end else begin
          chk("resp_valid", {63'h0, resp_valid}, 64'h1);
          chk("resp_data", {30'h0, resp_id, resp_carry, resp_result}, {30'h0, m_id, m_exp[32], m_exp[31:0]});
          chk("resp_alu", {27'h0, alu_inA, alu_inB, alu_opcode, alu_carry_in}, 64'h0);
          if (resp_ready) begin
            last_result = resp_result;
            last_carry  = resp_carry;
            last_id     = resp_id;
            last_lat    = m_first;
            txn_no++;
            $display("txn %0d: id=%0d op=%0h wide=%0d a=%h b=%h result=%h carry=%0d lat=%0d",
                     txn_no, resp_id, m_op, m_wide, m_a, m_b, resp_result, resp_carry, m_first);
            m_busy = 0;
            m_ptr  = ~m_id;
          end
        end
      end
    end
  endtask

  task automatic set_req(input int n, input logic [3:0] op, input logic wide,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_opcode = op; req0_wide = wide; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_opcode = op; req1_wide = wide; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_ready(input int n);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("ready_timeout", 64'h0, 64'h1);
    @(posedge clk);
    #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic handshake(input int hold, input bit drop_all);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("resp_timeout", 64'h0, 64'h1);
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    if (drop_all) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic chk_last(input string name, input logic [31:0] res, input logic c,
                          input logic id, input int lat);
    chk({name, "_result"}, {32'h0, last_result}, {32'h0, res});
    chk({name, "_carry"},  {63'h0, last_carry},  {63'h0, c});
    chk({name, "_id"},     {63'h0, last_id},     {63'h0, id});
    chk({name, "_lat"},    64'(last_lat),        64'(lat));
  endtask

  initial begin
    int rv;
    rst = 1'b1;
    req0_valid = 0; req0_opcode = 0; req0_wide = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_opcode = 0; req1_wide = 0; req1_a = 0; req1_b = 0;
    resp_ready = 0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention: both requesters valid continuously.
    grants.delete();
    set_req(0, FUNC_ADD, 1'b0, 32'h1, 32'h2);
    set_req(1, FUNC_SUB, 1'b1, 32'h5, 32'h7);
    repeat (3) handshake(0, 1'b0);
    handshake(0, 1'b1);
    chk("grant_count", 64'(grants.size()), 64'd4);
    if (grants.size() == 4) begin
      chk("grant_0", 64'(grants[0]), 64'd0);
      chk("grant_1", 64'(grants[1]), 64'd1);
      chk("grant_2", 64'(grants[2]), 64'd0);
      chk("grant_3", 64'(grants[3]), 64'd1);
    end
    chk_last("wide_sub", 32'hFFFF_FFFE, 1'b1, 1'b1, 3);

    // Narrow add with carry out.
    @(posedge clk); #1;
    set_req(0, FUNC_ADD, 1'b0, 32'h0000_8000, 32'h0000_8000);
    wait_ready(0);
    handshake(0, 1'b0);
    chk_last("narrow_add", 32'h0000_0000, 1'b1, 1'b0, 2);

    // Wide add, carry chains into the high pass.
    @(posedge clk); #1;
    set_req(1, FUNC_ADD, 1'b1, 32'h0000_FFFF, 32'h0000_0001);
    wait_ready(1);
    handshake(0, 1'b0);
    chk_last("wide_add", 32'h0001_0000, 1'b0, 1'b1, 3);
    chk("wide_add_hi_cin", {63'h0, last_hi_cin}, 64'h1);

    // Wide overflow under backpressure, other requester waiting.
    @(posedge clk); #1;
    set_req(0, FUNC_ADD, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    set_req(1, FUNC_XOR, 1'b0, 32'hABCD_F0F0, 32'h0000_FFFF);
    wait_ready(0);
    handshake(5, 1'b0);
    chk_last("wide_ovf", 32'h0000_0000, 1'b1, 1'b0, 3);
    wait_ready(1);
    handshake(0, 1'b0);
    chk_last("narrow_xor", 32'h0000_0F0F, 1'b0, 1'b1, 2);

    // Narrow subtract underflow; upper operand bits must be ignored.
    @(posedge clk); #1;
    set_req(0, FUNC_SUB, 1'b0, 32'h1234_0000, 32'h0000_0001);
    wait_ready(0);
    handshake(0, 1'b0);
    chk_last("narrow_sub", 32'h0000_FFFF, 1'b1, 1'b0, 2);

    // Reset during the HI pass of a wide op from requester 1.
    @(posedge clk); #1;
    set_req(1, FUNC_OR, 1'b1, 32'h1111_0000, 32'h0000_2222);
    wait_ready(1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    rv = 0;
    repeat (6) begin
      @(negedge clk);
      rv += int'(resp_valid);
    end
    chk("no_resp_after_rst", 64'(rv), 64'd0);

    grants.delete();
    @(posedge clk); #1;
    set_req(0, FUNC_AND, 1'b0, 32'h0000_FFFF, 32'h0000_0F0F);
    set_req(1, FUNC_ADD, 1'b0, 32'h3, 32'h4);
    wait_ready(0);
    chk("post_rst_grant", (grants.size() > 0) ? 64'(grants[0]) : 64'hFF, 64'd0);
    handshake(0, 1'b0);
    chk_last("narrow_and", 32'h0000_0F0F, 1'b0, 1'b0, 2);
    wait_ready(1);
    handshake(0, 1'b0);
    chk_last("narrow_add2", 32'h0000_0007, 1'b0, 1'b1, 2);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
